// File: rtl/hex_display_arbiter.sv
// Round-robin write arbiter for the eight seven-segment digits: requesters write nibbles into a
// shared register file. Define HEXARB_BLINK_EN to build the per-digit blink attribute and prescaler.
module hex_display_arbiter #(
    parameter int NREQ      = 4,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic              iCLK_50,
    input  logic              iRST_N,
    input  logic [NREQ-1:0]   iREQ,
    input  logic [3*NREQ-1:0] iADDR,
    input  logic [4*NREQ-1:0] iDATA,
    input  logic [NREQ-1:0]   iBLINK,
    output logic [NREQ-1:0]   oGNT,
    output logic [31:0]       oDIGITS,
    output logic [7:0]        oBLANK,
    output logic              oBUSY
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [2:0]      addr_q, addr_d;
    logic [3:0]      data_q, data_d;
    logic [31:0]     digits_q, digits_d;
    logic [7:0]      valid_q, valid_d;
    logic            found;
    logic [PW-1:0]   win;

`ifdef HEXARB_BLINK_EN
    localparam int CW = $clog2(BLINK_DIV);
    logic          blk_q, blk_d;
    logic [7:0]    blink_q, blink_d;
    logic [CW-1:0] presc_q, presc_d;
    logic          phase_q, phase_d;
`else
    logic unused_blink;
    assign unused_blink = ^{iBLINK, BLINK_DIV[0]};
`endif

    // Search from the pointer upwards, wrapping, for the first active request.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && iREQ[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = '0;
        addr_d   = addr_q;
        data_d   = data_q;
        digits_d = digits_q;
        valid_d  = valid_q;
`ifdef HEXARB_BLINK_EN
        blk_d    = blk_q;
        blink_d  = blink_q;
        presc_d  = (presc_q == CW'(BLINK_DIV - 1)) ? '0 : presc_q + 1'b1;
        phase_d  = (presc_q == CW'(BLINK_DIV - 1)) ? ~phase_q : phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
                    addr_d  = iADDR[3*win +: 3];
                    data_d  = iDATA[4*win +: 4];
                    ptr_d   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
`ifdef HEXARB_BLINK_EN
                    blk_d   = iBLINK[win];
`endif
                end
            end
            GRANT: begin
                state_d                  = IDLE;
                digits_d[4*addr_q +: 4]  = data_q;
                valid_d[addr_q]          = 1'b1;
`ifdef HEXARB_BLINK_EN
                blink_d[addr_q]          = blk_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            digits_q <= '0;
            valid_q  <= '0;
`ifdef HEXARB_BLINK_EN
            blk_q    <= 1'b0;
            blink_q  <= '0;
            presc_q  <= '0;
            phase_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
`ifdef HEXARB_BLINK_EN
            blk_q    <= blk_d;
            blink_q  <= blink_d;
            presc_q  <= presc_d;
            phase_q  <= phase_d;
`endif
        end
    end

    assign oGNT    = gnt_q;
    assign oDIGITS = digits_q;
    assign oBUSY   = (state_q == GRANT);
`ifdef HEXARB_BLINK_EN
    assign oBLANK  = ~valid_q | (blink_q & {8{phase_q}});
`else
    assign oBLANK  = ~valid_q;
`endif
endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with a per-cycle reference model of the digit file,
// round-robin pointer and blink phase.
module tb_hex_display_arbiter;
    localparam int NREQ = 4;
    localparam int BDIV = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [3*NREQ-1:0] addr = '0;
    logic [4*NREQ-1:0] data = '0;
    logic [NREQ-1:0]   blink = '0;
    logic [NREQ-1:0]   gnt;
    logic [31:0]       digits;
    logic [7:0]        blank;
    logic              busy;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    hex_display_arbiter #(.NREQ(NREQ), .BLINK_DIV(BDIV)) dut (
        .iCLK_50(clk), .iRST_N(rst_n), .iREQ(req), .iADDR(addr), .iDATA(data),
        .iBLINK(blink), .oGNT(gnt), .oDIGITS(digits), .oBLANK(blank), .oBUSY(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending write, the digit array and a cycle count since reset.
    logic [3:0]      m_dig [8];
    logic [7:0]      m_val;
    logic [7:0]      m_blk;
    int              m_ptr, m_n, m_a, m_d;
    bit              m_pend, m_b;
    logic [NREQ-1:0] m_gnt;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_dig[i] <= 4'h0;
            m_val <= '0; m_blk <= '0; m_ptr <= 0; m_n <= 0;
            m_pend <= 1'b0; m_gnt <= '0; m_a <= 0; m_d <= 0; m_b <= 1'b0;
        end else begin
            m_n <= m_n + 1;
            if (m_pend) begin
                m_dig[m_a] <= m_d[3:0];
                m_val[m_a] <= 1'b1;
                m_blk[m_a] <= m_b;
                m_pend     <= 1'b0;
                m_gnt      <= '0;
            end else if (rr_pick(req, m_ptr) >= 0) begin
                m_pend <= 1'b1;
                m_a    <= int'(addr[3*rr_pick(req, m_ptr) +: 3]);
                m_d    <= int'(data[4*rr_pick(req, m_ptr) +: 4]);
                m_b    <= blink[rr_pick(req, m_ptr)];
                m_gnt  <= NREQ'(1) << rr_pick(req, m_ptr);
                m_ptr  <= (rr_pick(req, m_ptr) + 1) % NREQ;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] e_dig;
            logic [7:0]  e_blank;
            for (int i = 0; i < 8; i++) begin
                e_dig[4*i +: 4] = m_dig[i];
`ifdef HEXARB_BLINK_EN
                e_blank[i] = ~m_val[i] | (m_blk[i] & (((m_n / BDIV) % 2) == 1));
`else
                e_blank[i] = ~m_val[i];
`endif
            end
            check("model_gnt", 32'(gnt), 32'(m_gnt));
            check("model_busy", 32'(busy), 32'(m_pend));
            check("model_digits", digits, e_dig);
            check("model_blank", 32'(blank), 32'(e_blank));
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_req(input int r, input int a, input int d, input bit b);
        addr[3*r +: 3] = 3'(a);
        data[4*r +: 4] = 4'(d);
        blink[r]       = b;
        req[r]         = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NREQ-1:0] eg;
        int toggles;
        logic prev;

        // Reset state
        do_reset();
        chk_en = 1'b1;
        check("rst_digits", digits, 32'h0);
        check("rst_blank", 32'(blank), 32'hFF);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Single write: requester 0 -> digit 3 = A
        set_req(0, 3, 4'hA, 1'b0);
        step();
        check("single_gnt", 32'(gnt), 32'h1);
        check("single_busy", 32'(busy), 32'h1);
        req[0] = 1'b0;
        step();
        check("single_gnt_drop", 32'(gnt), 32'h0);
        check("single_digits", digits, 32'h0000_A000);
        check("single_blank", 32'(blank), 32'hF7);

        // Round-robin with all requests held high
        do_reset();
        for (int r = 0; r < NREQ; r++) set_req(r, r, r + 1, 1'b0);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            step();
            eg = (cyc % 2 == 1) ? NREQ'(1) << (((cyc - 1) / 2) % NREQ) : '0;
            check($sformatf("rr_gnt_c%0d", cyc), 32'(gnt), 32'(eg));
        end
        req = '0;
        step();
        check("rr_digits", digits, 32'h0000_4321);

        // Same-digit collision from p=0
        do_reset();
        set_req(1, 0, 5, 1'b0);
        set_req(2, 0, 7, 1'b0);
        step();
        check("col_gnt1", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        step();
        check("col_dig_first", 32'(digits[3:0]), 32'h5);
        step();
        check("col_gnt2", 32'(gnt), 32'h4);
        req[2] = 1'b0;
        step();
        check("col_dig_last", 32'(digits[3:0]), 32'h7);

        // Async reset during GRANT aborts the write and leaves p=0
        do_reset();
        set_req(1, 5, 9, 1'b0);
        step();
        check("ar_gnt", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_gnt_drop", 32'(gnt), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_digits", digits, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        set_req(0, 1, 3, 1'b0);
        set_req(2, 2, 6, 1'b0);
        step();
        check("ar_ptr0", 32'(gnt), 32'h1);
        req[0] = 1'b0;
        step();
        check("ar_blank", 32'(blank), 32'hFD);
        req[2] = 1'b0;
        step();

        // Blink on digit 7
        do_reset();
        set_req(0, 7, 4'hE, 1'b1);
        step();
        req[0] = 1'b0;
        step();
        check("bl_digits", digits, 32'hE000_0000);
        toggles = 0;
        @(negedge clk);
        prev = blank[7];
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (blank[7] !== prev) toggles++;
            prev = blank[7];
`ifndef HEXARB_BLINK_EN
            check($sformatf("bl_steady_%0d", i), 32'(blank), 32'h7F);
`endif
        end
`ifdef HEXARB_BLINK_EN
        check("bl_toggles", 32'(toggles), 32'd2);
`else
        check("bl_toggles", 32'(toggles), 32'd0);
`endif

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Shared-resource controller for the eight DE2-70 seven-segment digits. Up to NREQ requesters write 4-bit values to individual digits over a req/grant handshake; a round-robin arbiter serialises writes into an 8-entry nibble register file whose contents drive the eight `decoder7` instances in the top level. The block also tracks which digits have been written since reset and, optionally, blinks selected digits from a 50 MHz prescaler.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `BLINK_DIV`, default 25_000_000: clock cycles per blink half-period (0.5 s at 50 MHz), ≥ 2.

- `iCLK_50` in 1: system clock, 50 MHz.
- `iRST_N` in 1: reset, asynchronous, active-low.
- `iREQ` in NREQ: write request per requester. It must be held until the matching `oGNT` bit is seen high.
- `iADDR` in 3*NREQ: target digit for requester r, in [3r+2:3r].
- `iDATA` in 4*NREQ: nibble for requester r, in [4r+3:4r].
- `iBLINK` in NREQ: blink attribute written with the nibble.
- `oGNT` out NREQ: one-hot grant, high for exactly one cycle per accepted write.
- `oDIGITS` out 32: digit i value in [4i+3:4i], for direct connection to `decoder7`.
- `oBLANK` out 8: digit i must be driven dark by the top level.
- `oBUSY` out 1: high while in GRANT.

## Operation
- FSM states: IDLE and GRANT.
- **IDLE**:
  - If any `iREQ` bit is high at a clock edge, select winner w by round-robin.
  - Latch `iADDR`/`iDATA`/`iBLINK` of w, set `oGNT[w]`, and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**:
  - At the next edge, write the latched nibble to `digit[addr]`, set `valid[addr]`, and store `blink[addr]`.
  - Clear `oGNT` and return to IDLE unconditionally. There is no back-to-back grant.
- **Round-robin**:
  - Pointer p, 0..NREQ-1.
  - Search p, p+1, … modulo NREQ; the first requester with `iREQ` high wins.
  - After a grant to w, p becomes (w+1) mod NREQ. Wrap from NREQ-1 to 0.
- **Blanking**: `oBLANK[i] = ~valid[i] | (blink[i] & phase)` with the blink feature built; otherwise `oBLANK[i] = ~valid[i]`.
- **Boundary conditions**:
  - Multiple writes to the same digit: the last grant wins.
  - Writing the same value again still pulses `oGNT`.
  - Requester drops `iREQ` while in GRANT (protocol violation): the write still completes with the latched data.
  - `iADDR` is 3 bits, so every value is a valid digit. Out-of-range requester bits above NREQ do not exist.
  - Reset asserted mid-GRANT: the write is aborted and `oGNT` drops immediately (asynchronous).

## Timing
- Reset values:
  - state IDLE, p=0, `oGNT`=0, `oBUSY`=0, `oDIGITS`=32'h0.
  - `valid`=0, so `oBLANK`=8'hFF.
  - `blink`=0, phase=0, prescaler=0.
- Requester protocol:
  - `iREQ` high before edge e0 → `oGNT[w]` high between e0 and e1.
  - The requester deasserts `iREQ` at e1.
  - `oDIGITS`/`oBLANK` reflect the write after e1.
- Grant latency is 1 cycle from the sampled request. Write visibility is 2 cycles.
- Maximum throughput is one write per 2 cycles, system-wide.
- All outputs are registered, except `oBLANK`, which is combinational from registers.

## Configuration
- `HEXARB_BLINK_EN` defined:
  - Prescaler counts 0..BLINK_DIV-1 and toggles phase at wrap. Width is $clog2(BLINK_DIV).
  - Digits with `blink`=1 alternate dark/lit every BLINK_DIV cycles.
- Undefined:
  - No prescaler or blink register is built.
  - `iBLINK` is ignored.
  - `oBLANK = ~valid`.

## Test plan
- **Reset and single write**: reset → `oDIGITS`=0, `oBLANK`=FF. Requester 0 writes digit 3=4'hA → `oGNT`=0001 for exactly 1 cycle; `oDIGITS[15:12]`=A and `oBLANK`=F7 two cycles after request.
- **Round-robin**: all 4 `iREQ` high continuously (each re-raised after its grant), p=0 → grants 0,1,2,3,0 on cycles 1,3,5,7,9.
- **Same-digit collision**: req1 writes digit 0=5 and req2 writes digit 0=7 simultaneously from p=0 → grant 1 then 2; final `oDIGITS[3:0]`=7.
- **Async reset mid-GRANT**: `iRST_N` low during the GRANT cycle → `oGNT` low within the cycle, no digit updated, p=0.
- **Blink, with `HEXARB_BLINK_EN` and BLINK_DIV=4**: write digit 7 with `iBLINK`=1 → `oBLANK[7]` toggles every 4 cycles; the other digits are unaffected. Without the macro, `oBLANK[7]` stays 0.
